// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter sharing one slave read port and one slave write port among NUM_M masters.
// Each channel holds its grant from address acceptance until RLAST (read) or the B handshake (write).
module slave_port_arbiter #(
    parameter int NUM_M = 3,
    parameter int AR_W  = 16,
    parameter int AW_W  = 12,
    parameter int D_W   = 8,
    parameter int B_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    // master read side
    input  logic [NUM_M-1:0]       m_arvalid,
    input  logic [NUM_M*AR_W-1:0]  m_ar,
    output logic [NUM_M-1:0]       m_arready,
    output logic [NUM_M-1:0]       m_rvalid,
    output logic [D_W-1:0]         m_rdata,
    output logic                   m_rlast,
    input  logic [NUM_M-1:0]       m_rready,
    // master write side
    input  logic [NUM_M-1:0]       m_awvalid,
    output logic [NUM_M-1:0]       m_awready,
    input  logic [NUM_M*AW_W-1:0]  m_aw,
    input  logic [NUM_M-1:0]       m_wvalid,
    input  logic [NUM_M-1:0]       m_wlast,
    input  logic [NUM_M*D_W-1:0]   m_wdata,
    output logic [NUM_M-1:0]       m_wready,
    output logic [NUM_M-1:0]       m_bvalid,
    output logic [B_W-1:0]         m_bresp,
    input  logic [NUM_M-1:0]       m_bready,
    // slave read side
    output logic                   s_arvalid,
    output logic [AR_W-1:0]        s_ar,
    output logic                   s_rready,
    input  logic                   s_arready,
    input  logic                   s_rvalid,
    input  logic [D_W-1:0]         s_rdata,
    input  logic                   s_rlast,
    // slave write side
    output logic                   s_awvalid,
    output logic [AW_W-1:0]        s_aw,
    output logic                   s_wvalid,
    output logic [D_W-1:0]         s_wdata,
    output logic                   s_wlast,
    output logic                   s_bready,
    input  logic                   s_awready,
    input  logic                   s_wready,
    input  logic                   s_bvalid,
    input  logic [B_W-1:0]         s_bresp,
    // status
    output logic [1:0]             r_grant,
    output logic [1:0]             w_grant,
    output logic                   r_busy,
    output logic                   w_busy
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    localparam logic [1:0] LAST_INIT = 2'(NUM_M - 1);

    // First requester at or after last+1, wrapping; the lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [NUM_M-1:0] req, input logic [1:0] last);
        logic [1:0] pick;
        int         idx;
        pick = last;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_M;
            if (req[2'(idx)]) pick = 2'(idx);
        end
        return pick;
    endfunction

    // ---------------------------------------------------------------- read channel
    r_state_t         r_state_reg, r_state_next;
    logic [1:0]       r_last_reg;
    logic [1:0]       r_grant_reg;
    logic [1:0]       r_sel;
    logic             r_start;
    logic             s_arvalid_reg;
    logic [AR_W-1:0]  s_ar_reg;
    logic             r_done;

    assign r_sel   = rr_pick(m_arvalid, r_last_reg);
    assign r_start = !rst && (r_state_reg == R_IDLE) && (|m_arvalid);
    assign r_done  = (r_state_reg == R_DATA) && s_rvalid && s_rready && s_rlast;

    always_comb begin
        r_state_next = r_state_reg;
        s_rready     = 1'b0;
        m_rdata      = '0;
        m_rlast      = 1'b0;
        case (r_state_reg)
            R_IDLE: if (r_start) r_state_next = R_ADDR;
            R_ADDR: if (s_arvalid_reg && s_arready) r_state_next = R_DATA;
            R_DATA: begin
                s_rready = m_rready[r_grant_reg];
                m_rdata  = s_rdata;
                m_rlast  = s_rlast;
                if (s_rvalid && m_rready[r_grant_reg] && s_rlast) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg   <= R_IDLE;
            r_last_reg    <= LAST_INIT;
            r_grant_reg   <= '0;
            s_arvalid_reg <= 1'b0;
            s_ar_reg      <= '0;
        end else begin
            r_state_reg <= r_state_next;
            if (r_start) begin
                s_ar_reg      <= m_ar[int'(r_sel)*AR_W +: AR_W];
                r_grant_reg   <= r_sel;
                s_arvalid_reg <= 1'b1;
            end else if ((r_state_reg == R_ADDR) && s_arready) begin
                s_arvalid_reg <= 1'b0;
            end
            if (r_done) r_last_reg <= r_grant_reg;
        end
    end

    assign s_arvalid = s_arvalid_reg;
    assign s_ar      = s_ar_reg;
    assign r_grant   = r_grant_reg;
    assign r_busy    = (r_state_reg != R_IDLE);

    // ---------------------------------------------------------------- write channel
    w_state_t         w_state_reg, w_state_next;
    logic [1:0]       w_last_reg;
    logic [1:0]       w_grant_reg;
    logic [1:0]       w_sel;
    logic             w_start;
    logic             s_awvalid_reg;
    logic [AW_W-1:0]  s_aw_reg;
    logic             w_done;

    assign w_sel   = rr_pick(m_awvalid, w_last_reg);
    assign w_start = !rst && (w_state_reg == W_IDLE) && (|m_awvalid);
    assign w_done  = (w_state_reg == W_RESP) && s_bvalid && s_bready;

    always_comb begin
        w_state_next = w_state_reg;
        s_wvalid     = 1'b0;
        s_wdata      = '0;
        s_wlast      = 1'b0;
        s_bready     = 1'b0;
        m_bresp      = '0;
        case (w_state_reg)
            W_IDLE: if (w_start) w_state_next = W_ADDR;
            W_ADDR: if (s_awvalid_reg && s_awready) w_state_next = W_DATA;
            W_DATA: begin
                s_wvalid = m_wvalid[w_grant_reg];
                s_wdata  = m_wdata[int'(w_grant_reg)*D_W +: D_W];
                s_wlast  = m_wlast[w_grant_reg];
                if (m_wvalid[w_grant_reg] && s_wready && m_wlast[w_grant_reg])
                    w_state_next = W_RESP;
            end
            W_RESP: begin
                s_bready = m_bready[w_grant_reg];
                m_bresp  = s_bresp;
                if (s_bvalid && m_bready[w_grant_reg]) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_reg   <= W_IDLE;
            w_last_reg    <= LAST_INIT;
            w_grant_reg   <= '0;
            s_awvalid_reg <= 1'b0;
            s_aw_reg      <= '0;
        end else begin
            w_state_reg <= w_state_next;
            if (w_start) begin
                s_aw_reg      <= m_aw[int'(w_sel)*AW_W +: AW_W];
                w_grant_reg   <= w_sel;
                s_awvalid_reg <= 1'b1;
            end else if ((w_state_reg == W_ADDR) && s_awready) begin
                s_awvalid_reg <= 1'b0;
            end
            if (w_done) w_last_reg <= w_grant_reg;
        end
    end

    assign s_awvalid = s_awvalid_reg;
    assign s_aw      = s_aw_reg;
    assign w_grant   = w_grant_reg;
    assign w_busy    = (w_state_reg != W_IDLE);

    // ---------------------------------------------------------------- per-master steering
    // Only the granted master sees valid/ready; the accept strobes are forced low during reset.
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_master
        assign m_arready[gi] = r_start && (r_sel == 2'(gi));
        assign m_rvalid[gi]  = (r_state_reg == R_DATA) && (r_grant_reg == 2'(gi)) && s_rvalid;
        assign m_awready[gi] = w_start && (w_sel == 2'(gi));
        assign m_wready[gi]  = (w_state_reg == W_DATA) && (w_grant_reg == 2'(gi)) && s_wready;
        assign m_bvalid[gi]  = (w_state_reg == W_RESP) && (w_grant_reg == 2'(gi)) && s_bvalid;
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter: arbitration order, grant locking, routing and async reset.
module tb_slave_port_arbiter;

    localparam int NUM_M = 3;
    localparam int AR_W  = 16;
    localparam int AW_W  = 12;
    localparam int D_W   = 8;
    localparam int B_W   = 5;

    logic                  clk;
    logic                  rst;
    logic [NUM_M-1:0]      m_arvalid;
    logic [NUM_M*AR_W-1:0] m_ar;
    logic [NUM_M-1:0]      m_arready;
    logic [NUM_M-1:0]      m_rvalid;
    logic [D_W-1:0]        m_rdata;
    logic                  m_rlast;
    logic [NUM_M-1:0]      m_rready;
    logic [NUM_M-1:0]      m_awvalid;
    logic [NUM_M-1:0]      m_awready;
    logic [NUM_M*AW_W-1:0] m_aw;
    logic [NUM_M-1:0]      m_wvalid;
    logic [NUM_M-1:0]      m_wlast;
    logic [NUM_M*D_W-1:0]  m_wdata;
    logic [NUM_M-1:0]      m_wready;
    logic [NUM_M-1:0]      m_bvalid;
    logic [B_W-1:0]        m_bresp;
    logic [NUM_M-1:0]      m_bready;
    logic                  s_arvalid;
    logic [AR_W-1:0]       s_ar;
    logic                  s_rready;
    logic                  s_arready;
    logic                  s_rvalid;
    logic [D_W-1:0]        s_rdata;
    logic                  s_rlast;
    logic                  s_awvalid;
    logic [AW_W-1:0]       s_aw;
    logic                  s_wvalid;
    logic [D_W-1:0]        s_wdata;
    logic                  s_wlast;
    logic                  s_bready;
    logic                  s_awready;
    logic                  s_wready;
    logic                  s_bvalid;
    logic [B_W-1:0]        s_bresp;
    logic [1:0]            r_grant;
    logic [1:0]            w_grant;
    logic                  r_busy;
    logic                  w_busy;

    int checks = 0;
    int errors = 0;

    slave_port_arbiter #(
        .NUM_M(NUM_M), .AR_W(AR_W), .AW_W(AW_W), .D_W(D_W), .B_W(B_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_ar(m_ar), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .s_arvalid(s_arvalid), .s_ar(s_ar), .s_rready(s_rready),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .s_awvalid(s_awvalid), .s_aw(s_aw), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wlast(s_wlast), .s_bready(s_bready),
        .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
        .r_grant(r_grant), .w_grant(w_grant), .r_busy(r_busy), .w_busy(w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] order [4];
        logic [1:0] e;
        order = '{2'd0, 2'd1, 2'd2, 2'd0};

        rst = 1'b1;
        m_arvalid = '0; m_ar = '0; m_rready = '0;
        m_awvalid = '0; m_aw = '0; m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        tick();
        tick();

        // Reset state, with requests present to show the accept strobes stay low
        m_arvalid = 3'b111;
        m_awvalid = 3'b111;
        #1;
        check("rst_arready", 32'(m_arready), 32'h0);
        check("rst_awready", 32'(m_awready), 32'h0);
        check("rst_s_arvalid", 32'(s_arvalid), 32'h0);
        check("rst_busy", 32'({r_busy, w_busy}), 32'h0);
        check("rst_grants", 32'({r_grant, w_grant}), 32'h0);
        check("rst_rvalid", 32'(m_rvalid), 32'h0);
        m_arvalid = '0;
        m_awvalid = '0;
        rst = 1'b0;
        tick();

        // Test 1: master 1 alone, 4-beat read
        m_ar = {16'h3333, 16'hBEEF, 16'h1111};
        m_arvalid = 3'b010;
        #1;
        check("t1_arready", 32'(m_arready), 32'h2);
        tick();
        m_arvalid = '0;
        check("t1_s_arvalid", 32'(s_arvalid), 32'h1);
        check("t1_s_ar", 32'(s_ar), 32'hBEEF);
        check("t1_r_grant", 32'(r_grant), 32'h1);
        check("t1_r_busy", 32'(r_busy), 32'h1);
        check("t1_arready_low", 32'(m_arready), 32'h0);
        tick();
        check("t1_ar_hold", 32'({s_arvalid, s_ar}), 32'h1BEEF);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        check("t1_ar_drop", 32'(s_arvalid), 32'h0);
        m_rready = 3'b010;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = 8'(8'h10 + k);
            s_rlast  = (k == 3);
            #1;
            check("t1_m_rvalid", 32'(m_rvalid), 32'h2);
            check("t1_m_rdata", 32'(m_rdata), 32'(8'h10 + k));
            check("t1_s_rready", 32'(s_rready), 32'h1);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = '0;
        check("t1_busy_drop", 32'(r_busy), 32'h0);

        // Test 2: pointer reset, then all three requesting 1-beat reads
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_ar = {16'hA002, 16'hA001, 16'hA000};
        m_arvalid = 3'b111;
        m_rready = 3'b111;
        for (int n = 0; n < 4; n++) begin
            e = order[n];
            #1;
            check("t2_arready", 32'(m_arready), 32'(3'b001 << e));
            tick();
            check("t2_r_grant", 32'(r_grant), 32'(e));
            check("t2_s_ar", 32'(s_ar), 32'(16'hA000 + 16'(e)));
            s_arready = 1'b1;
            tick();
            s_arready = 1'b0;
            s_rvalid = 1'b1;
            s_rlast = 1'b1;
            s_rdata = 8'(8'h20 + n);
            #1;
            check("t2_m_rvalid", 32'(m_rvalid), 32'(3'b001 << e));
            check("t2_m_rlast", 32'(m_rlast), 32'h1);
            tick();
            s_rvalid = 1'b0;
            s_rlast = 1'b0;
            check("t2_idle", 32'(r_busy), 32'h0);
        end
        m_arvalid = '0;
        m_rready = '0;

        // Test 3: master 2 writes two beats with slave stalling, then BRESP 3
        m_aw = {12'h5A5, 12'h222, 12'h111};
        m_awvalid = 3'b100;
        #1;
        check("t3_awready", 32'(m_awready), 32'h4);
        tick();
        m_awvalid = '0;
        check("t3_s_aw", 32'({s_awvalid, s_aw}), 32'h15A5);
        check("t3_w_grant", 32'(w_grant), 32'h2);
        check("t3_w_busy", 32'(w_busy), 32'h1);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        m_wvalid = 3'b101;
        m_wdata = {8'hC1, 8'h00, 8'hEE};
        m_wlast = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_wvalid", 32'(s_wvalid), 32'h1);
            check("t3_stall_wdata", 32'(s_wdata), 32'hC1);
            check("t3_stall_wlast", 32'(s_wlast), 32'h0);
            check("t3_stall_wready", 32'(m_wready), 32'h0);
            tick();
        end
        s_wready = 1'b1;
        #1;
        check("t3_beat1_wready", 32'(m_wready), 32'h4);
        tick();
        m_wdata = {8'hC2, 8'h00, 8'hEE};
        m_wlast = 3'b101;
        #1;
        check("t3_beat2", 32'({s_wlast, s_wdata}), 32'h1C2);
        tick();
        m_wvalid = '0;
        m_wlast = '0;
        s_wready = 1'b0;
        s_bvalid = 1'b1;
        s_bresp = 5'h03;
        m_bready = 3'b100;
        #1;
        check("t3_m_bvalid", 32'(m_bvalid), 32'h4);
        check("t3_m_bresp", 32'(m_bresp), 32'h3);
        check("t3_s_bready", 32'(s_bready), 32'h1);
        check("t3_resp_grant", 32'(w_grant), 32'h2);
        check("t3_resp_no_w", 32'({s_wvalid, m_wready}), 32'h0);
        tick();
        s_bvalid = 1'b0;
        m_bready = '0;
        check("t3_idle", 32'({w_busy, m_bvalid}), 32'h0);

        // Test 4: master 0 read and master 2 write concurrently
        m_ar = {16'h3333, 16'h2222, 16'h0C0C};
        m_aw = {12'h2A2, 12'h222, 12'h111};
        m_arvalid = 3'b001;
        m_awvalid = 3'b100;
        #1;
        check("t4_arready", 32'(m_arready), 32'h1);
        check("t4_awready", 32'(m_awready), 32'h4);
        tick();
        m_arvalid = '0;
        m_awvalid = '0;
        check("t4_grants", 32'({r_grant, w_grant}), 32'h2);
        check("t4_s_ar", 32'(s_ar), 32'h0C0C);
        check("t4_s_aw", 32'(s_aw), 32'h2A2);
        s_arready = 1'b1;
        s_awready = 1'b1;
        tick();
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_rvalid = 1'b1;
        s_rlast = 1'b1;
        s_rdata = 8'h5A;
        m_rready = 3'b111;
        m_wvalid = 3'b101;
        m_wdata = {8'h2E, 8'h00, 8'h0E};
        m_wlast = 3'b101;
        s_wready = 1'b1;
        #1;
        check("t4_m_rvalid", 32'(m_rvalid), 32'h1);
        check("t4_s_wdata", 32'(s_wdata), 32'h2E);
        check("t4_m_wready", 32'(m_wready), 32'h4);
        tick();
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        m_wvalid = '0;
        m_wlast = '0;
        s_wready = 1'b0;
        s_bvalid = 1'b1;
        s_bresp = 5'h11;
        m_bready = 3'b111;
        #1;
        check("t4_m_bvalid", 32'(m_bvalid), 32'h4);
        check("t4_m_bresp", 32'(m_bresp), 32'h11);
        check("t4_read_done", 32'(r_busy), 32'h0);
        tick();
        s_bvalid = 1'b0;
        m_bready = '0;
        m_rready = '0;
        check("t4_write_done", 32'(w_busy), 32'h0);

        // Test 5: reset during the second beat of a master 1 read
        m_arvalid = 3'b010;
        tick();
        m_arvalid = '0;
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        s_rlast = 1'b0;
        s_rdata = 8'h01;
        m_rready = 3'b010;
        tick();
        s_rdata = 8'h02;
        #1;
        check("t5_beat2_rvalid", 32'(m_rvalid), 32'h2);
        m_arvalid = 3'b101;
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_rvalid", 32'(m_rvalid), 32'h0);
        check("t5_rst_rready", 32'(s_rready), 32'h0);
        check("t5_rst_busy", 32'(r_busy), 32'h0);
        check("t5_rst_grant", 32'(r_grant), 32'h0);
        check("t5_rst_arready", 32'(m_arready), 32'h0);
        check("t5_rst_rdata", 32'(m_rdata), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("t5_ptr_reset_pick", 32'(m_arready), 32'h1);
        // Stray slave beat while idle must not leak through
        check("t6_stray_rready", 32'(s_rready), 32'h0);
        check("t6_stray_rvalid", 32'(m_rvalid), 32'h0);
        m_arvalid = 3'b100;
        #1;
        check("t5_m2_alone", 32'(m_arready), 32'h4);
        m_arvalid = '0;
        tick();
        check("t5_withdrawn_ignored", 32'({r_busy, s_arvalid}), 32'h0);
        s_rvalid = 1'b0;
        m_rready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
